// File: rtl/lcd_bus_reader.sv
// Read-side HD44780 bus controller: one RW=1 read cycle per start edge, with optional
// busy-flag polling bounded by POLL_MAX.
module lcd_bus_reader #(
  parameter int CLK_Divide = 16,
  parameter int SETUP_CYC  = 2,
  parameter int HOLD_CYC   = 2,
  parameter int POLL_MAX   = 4095
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPoll,
  input  logic       iAbort,
  output logic [7:0] oData,
  output logic       oDone,
  output logic       oTimeout,
  output logic       oBusOwn,
  input  logic [7:0] LCD_DATA_IN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  // state | meaning
  // IDLE  | bus released, waiting for a start edge
  // SETUP | RS/RW driven, EN low, address setup time
  // EN_HI | EN high, data sampled on the last cycle
  // HOLD  | EN low, RS/RW held; decides poll retry or finish
  // DONE  | transaction finished, oDone high, new start allowed
  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, DONE} state_t;

  localparam int CNT_MAX = (CLK_Divide > SETUP_CYC)
                         ? ((CLK_Divide > HOLD_CYC) ? CLK_Divide : HOLD_CYC)
                         : ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC);
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(CLK_Divide - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [11:0]   POLL_LIM   = 12'(POLL_MAX);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [11:0]   poll_cnt;
  logic          pre_start;
  logic          poll_q;
  logic          start_edge;
  logic          poll_busy;

  assign start_edge = ~pre_start & iStart;
  // LCD_RS carries the latched register select for the whole transaction
  assign poll_busy  = poll_q & ~LCD_RS & oData[7];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      poll_cnt  <= '0;
      pre_start <= 1'b0;
      poll_q    <= 1'b0;
      oData     <= '0;
      oDone     <= 1'b0;
      oTimeout  <= 1'b0;
      oBusOwn   <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_RW    <= 1'b0;
      LCD_EN    <= 1'b0;
    end else begin
      pre_start <= iStart;
      if (iAbort) begin
        state   <= IDLE;
        cnt     <= '0;
        oDone   <= 1'b0;
        oBusOwn <= 1'b0;
        LCD_RW  <= 1'b0;
        LCD_EN  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start_edge) begin
              state    <= SETUP;
              cnt      <= '0;
              poll_cnt <= '0;
              poll_q   <= iPoll;
              oDone    <= 1'b0;
              oTimeout <= 1'b0;
              oBusOwn  <= 1'b1;
              LCD_RW   <= 1'b1;
              LCD_RS   <= iRS;
            end
          end
          SETUP: begin
            if (cnt == SETUP_LAST) begin
              cnt    <= '0;
              LCD_EN <= 1'b1;
              state  <= EN_HI;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          EN_HI: begin
            if (cnt == EN_LAST) begin
              cnt    <= '0;
              LCD_EN <= 1'b0;
              oData  <= LCD_DATA_IN;
              if (poll_cnt != 12'hFFF) poll_cnt <= poll_cnt + 1'b1;
              state  <= HOLD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HOLD: begin
            if (cnt == HOLD_LAST) begin
              cnt <= '0;
              if (poll_busy && poll_cnt < POLL_LIM) begin
                state <= SETUP;
              end else begin
                if (poll_busy) oTimeout <= 1'b1;
                oDone   <= 1'b1;
                oBusOwn <= 1'b0;
                LCD_RW  <= 1'b0;
                state   <= DONE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Bench for lcd_bus_reader: a timeline model (read index/phase from cycles since start)
// checked every cycle, plus literal checks on the key edges of each scenario.
module tb_lcd_bus_reader;
  localparam int S = 2, D = 16, H = 2, P = S + D + H;
  localparam int PMAX = 4095;

  logic       iCLK = 1'b0, iRST_N = 1'b0, iStart = 1'b0, iRS = 1'b0, iPoll = 1'b0, iAbort = 1'b0;
  logic [7:0] LCD_DATA_IN = 8'h00;
  logic [7:0] oData, t_Data;
  logic       oDone, oTimeout, oBusOwn, LCD_RS, LCD_RW, LCD_EN;
  logic       t_Done, t_Timeout, t_BusOwn, t_RS, t_RW, t_EN;

  lcd_bus_reader dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iStart(iStart), .iRS(iRS), .iPoll(iPoll), .iAbort(iAbort),
    .oData(oData), .oDone(oDone), .oTimeout(oTimeout), .oBusOwn(oBusOwn),
    .LCD_DATA_IN(LCD_DATA_IN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN));

  // Second instance with a short poll limit, fed a permanently busy bus
  lcd_bus_reader #(.POLL_MAX(3)) dut_t (
    .iCLK(iCLK), .iRST_N(iRST_N), .iStart(iStart), .iRS(iRS), .iPoll(iPoll), .iAbort(iAbort),
    .oData(t_Data), .oDone(t_Done), .oTimeout(t_Timeout), .oBusOwn(t_BusOwn),
    .LCD_DATA_IN(8'hFF), .LCD_RS(t_RS), .LCD_RW(t_RW), .LCD_EN(t_EN));

  always #5 iCLK = ~iCLK;

  int edge_cnt = 0;
  always @(posedge iCLK) edge_cnt <= edge_cnt + 1;

  int checks = 0, fails = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at edge %0d", name, act, exp, edge_cnt);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at edge %0d", name, act, exp, edge_cnt);
    end
  endtask

  // EN pulse / high-cycle counters observed on both instances
  int en_pulses = 0, en_hi = 0, t_pulses = 0;
  logic en_prev = 1'b0, t_prev = 1'b0;
  always @(negedge iCLK) begin
    if (LCD_EN && !en_prev) en_pulses++;
    if (LCD_EN) en_hi++;
    if (t_EN && !t_prev) t_pulses++;
    en_prev = LCD_EN;
    t_prev  = t_EN;
  end

  // Transaction model
  bit         m_started = 0, m_tmo = 0, m_rs = 0;
  int         m_t0 = 0, m_end = 0, m_nreads = 0, m_abort_t = -1;
  logic [7:0] m_prev = 8'h00;
  logic [7:0] m_seq[$];
  logic [7:0] n_seq[$];

  function automatic logic [7:0] seq_at(int i);
    return m_seq[(i < m_seq.size()) ? i : m_seq.size() - 1];
  endfunction

  function automatic logic [7:0] data_after(int k);
    int d, c;
    d = k - m_t0;
    if (d < S + D) return m_prev;
    c = (d - S - D) / P + 1;
    if (c > m_nreads) c = m_nreads;
    return seq_at(c - 1);
  endfunction

  function automatic logic [7:0] model_data(int k);
    if (!m_started) return m_prev;
    if (m_abort_t >= 0 && k >= m_abort_t) return data_after(m_abort_t - 1);
    return data_after(k);
  endfunction

  int k, d;
  logic e_own, e_rw, e_en, e_done, e_tmo, e_rs;
  logic [7:0] e_data;
  always @(negedge iCLK) begin
    k = edge_cnt;
    e_own = 0; e_rw = 0; e_en = 0; e_done = 0; e_tmo = 0; e_rs = m_rs;
    e_data = model_data(k);
    if (m_started && !(m_abort_t >= 0 && k >= m_abort_t)) begin
      d = k - m_t0;
      if (k < m_end) begin
        e_own = 1; e_rw = 1;
        e_en  = ((d % P) >= S) && ((d % P) < S + D);
      end else begin
        e_done = 1; e_tmo = m_tmo;
      end
    end
    if (m_started && k >= m_t0) LCD_DATA_IN = seq_at((k - m_t0) / P);
    if (iRST_N) begin
      chk1("oBusOwn", oBusOwn, e_own);
      chk1("LCD_RW", LCD_RW, e_rw);
      chk1("LCD_EN", LCD_EN, e_en);
      chk1("LCD_RS", LCD_RS, e_rs);
      chk1("oDone", oDone, e_done);
      chk1("oTimeout", oTimeout, e_tmo);
      chk8("oData", oData, e_data);
    end
  end

  task automatic wait_edge(input int t);
    while (edge_cnt < t) @(negedge iCLK);
    #1;
  endtask

  // Starts a read; the caller fills n_seq with the bytes presented on successive reads
  task automatic start_read(input bit rs, input bit poll);
    logic [7:0] b;
    int n;
    @(negedge iCLK); #1;
    m_prev = model_data(edge_cnt);
    m_seq = n_seq;
    n = 1;
    if (poll && !rs) begin
      b = seq_at(0);
      while (b[7] && n < PMAX) begin n++; b = seq_at(n - 1); end
      m_tmo = b[7];
    end else m_tmo = 0;
    m_nreads = n;
    m_rs = rs;
    m_t0 = edge_cnt + 1;
    m_end = m_t0 + n * P;
    m_abort_t = -1;
    m_started = 1;
    iRS = rs; iPoll = poll; iStart = 1'b1;
    @(negedge iCLK); #1;
    iStart = 1'b0;
  endtask

  int t0, p0, h0, tp0;
  initial begin
    #1;
    chk1("reset_oBusOwn", oBusOwn, 1'b0);
    chk1("reset_LCD_EN", LCD_EN, 1'b0);
    chk8("reset_oData", oData, 8'h00);
    repeat (3) @(negedge iCLK);
    #1 iRST_N = 1'b1;
    repeat (2) @(negedge iCLK);

    // single data read
    p0 = en_pulses; h0 = en_hi;
    n_seq = {8'hA5};
    start_read(1'b1, 1'b0); t0 = m_t0;
    wait_edge(t0 + 17); chk8("single_data_before", oData, 8'h00);
    wait_edge(t0 + 18); chk8("single_data", oData, 8'hA5);
    wait_edge(t0 + 19); chk1("single_done_early", oDone, 1'b0);
    wait_edge(t0 + 20);
    chk1("single_done", oDone, 1'b1);
    chk1("single_own", oBusOwn, 1'b0);
    chk8("single_pulses", 8'(en_pulses - p0), 8'd1);
    chk8("single_en_width", 8'(en_hi - h0), 8'd16);

    // busy-flag poll: three busy reads then clear; also poll-timeout on dut_t
    p0 = en_pulses;
    n_seq = {8'h80, 8'h80, 8'h80, 8'h12};
    start_read(1'b0, 1'b1); t0 = m_t0;
    wait_edge(t0 + 79); chk1("poll_done_early", oDone, 1'b0);
    wait_edge(t0 + 80);
    chk1("poll_done", oDone, 1'b1);
    chk8("poll_data", oData, 8'h12);
    chk1("poll_tmo", oTimeout, 1'b0);
    chk8("poll_pulses", 8'(en_pulses - p0), 8'd4);

    tp0 = t_pulses;
    n_seq = {8'hFF, 8'hFF, 8'hFF, 8'h00};
    start_read(1'b0, 1'b1); t0 = m_t0;
    wait_edge(t0 + 59); chk1("tmo_done_early", t_Done, 1'b0);
    wait_edge(t0 + 60);
    chk1("tmo_timeout", t_Timeout, 1'b1);
    chk1("tmo_done", t_Done, 1'b1);
    chk8("tmo_data", t_Data, 8'hFF);
    chk8("tmo_pulses", 8'(t_pulses - tp0), 8'd3);
    wait_edge(t0 + 80);
    chk1("tmo_main_done", oDone, 1'b1);

    // start while busy is ignored
    p0 = en_pulses;
    n_seq = {8'h3C};
    start_read(1'b1, 1'b0); t0 = m_t0;
    wait_edge(t0 + 3); iStart = 1'b0;
    wait_edge(t0 + 4); iStart = 1'b1;
    wait_edge(t0 + 6); iStart = 1'b0;
    wait_edge(t0 + 25);
    chk8("busy_pulses", 8'(en_pulses - p0), 8'd1);
    chk8("busy_data", oData, 8'h3C);
    n_seq = {8'h47};
    start_read(1'b0, 1'b0); t0 = m_t0;
    wait_edge(t0); chk1("restart_clears_done", oDone, 1'b0);
    wait_edge(t0 + 20); chk8("restart_data", oData, 8'h47);

    // abort while EN is high
    n_seq = {8'h99};
    start_read(1'b1, 1'b0); t0 = m_t0;
    wait_edge(t0 + 9);
    m_abort_t = t0 + 10;
    iAbort = 1'b1;
    wait_edge(t0 + 10);
    iAbort = 1'b0;
    chk1("abort_en", LCD_EN, 1'b0);
    chk1("abort_rw", LCD_RW, 1'b0);
    chk1("abort_own", oBusOwn, 1'b0);
    chk1("abort_done", oDone, 1'b0);
    chk8("abort_data", oData, 8'h47);
    wait_edge(t0 + 30);

    // asynchronous reset mid-read
    n_seq = {8'h5A};
    start_read(1'b1, 1'b0); t0 = m_t0;
    wait_edge(t0 + 8);
    #2 iRST_N = 1'b0;
    m_started = 0; m_prev = 8'h00; m_rs = 0; m_tmo = 0;
    #1;
    chk1("areset_own", oBusOwn, 1'b0);
    chk1("areset_rw", LCD_RW, 1'b0);
    chk1("areset_en", LCD_EN, 1'b0);
    chk1("areset_rs", LCD_RS, 1'b0);
    chk8("areset_data", oData, 8'h00);
    repeat (2) @(negedge iCLK);
    #1 iRST_N = 1'b1;
    n_seq = {8'h6B};
    start_read(1'b1, 1'b0); t0 = m_t0;
    wait_edge(t0 + 19); chk1("post_reset_done_early", oDone, 1'b0);
    wait_edge(t0 + 20);
    chk1("post_reset_done", oDone, 1'b1);
    chk8("post_reset_data", oData, 8'h6B);
    repeat (3) @(negedge iCLK);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end
endmodule

// File: doc/lcd_bus_reader.md
# lcd_bus_reader

Read-side companion to the LCD write controller on the HD44780-style character LCD bus. It performs single read cycles (RW=1) to fetch either the busy flag/address counter (RS=0) or a data-RAM byte (RS=1). It can also poll the busy flag until it clears, with a bounded retry count. The block sits beside the write controller; the top level uses `oBusOwn` to select this block's RS/RW/EN drivers and tri-state the FPGA data-bus outputs.

## Interface
- `CLK_Divide`, default 16: iCLK cycles that LCD_EN is held high per read.
- `SETUP_CYC`, default 2: cycles RS/RW are stable before LCD_EN rises (≥1).
- `HOLD_CYC`, default 2: cycles RS/RW are held after LCD_EN falls (≥1).
- `POLL_MAX`, default 4095: maximum busy-flag reads in poll mode before timeout (1..4095).
- Ports:
  - `iCLK`  in  1  clock.
  - `iRST_N`  in  1  asynchronous, active-low reset.
  - `iStart`  in  1  a rising edge requests one read transaction.
  - `iRS`  in  1  register select, latched at start: 0 = busy flag/address, 1 = data RAM.
  - `iPoll`  in  1  latched at start; with iRS=0, repeat reads until BF (bit 7) = 0.
  - `iAbort`  in  1  synchronous, active-high; cancels any transaction.
  - `oData`  out  8  last sampled byte; holds until the next sample.
  - `oDone`  out  1  level; set at transaction end, cleared by the next accepted start.
  - `oTimeout`  out  1  level; set when poll mode exhausts POLL_MAX reads, cleared by the next accepted start.
  - `oBusOwn`  out  1  high while a read cycle owns the LCD bus.
  - `LCD_DATA_IN`  in  8  LCD data bus, as seen by the FPGA input buffer.
  - `LCD_RS`  out  1  register select to the LCD.
  - `LCD_RW`  out  1  1 during owned cycles, otherwise 0.
  - `LCD_EN`  out  1  enable strobe.

## Operation
- Reset (async): oData=0, oDone=0, oTimeout=0, oBusOwn=0, LCD_EN=0, LCD_RW=0, LCD_RS=0. The FSM goes to IDLE and all counters clear.
- Start detect: register `preStart<=iStart`. A start is accepted when `{preStart,iStart}==2'b01` and the FSM is in IDLE or DONE. Edges arriving in any other state are ignored and not queued.
- FSM states: IDLE, SETUP, EN_HI, HOLD, DONE.
  - IDLE/DONE → SETUP on an accepted start.
    - Latch iRS and iPoll.
    - Clear oDone and oTimeout; clear the poll counter.
    - Set oBusOwn=1, LCD_RW=1, LCD_RS=latched iRS.
  - SETUP: count SETUP_CYC cycles, then set LCD_EN=1 and go to EN_HI.
  - EN_HI: count CLK_Divide cycles. On the last cycle:
    - set LCD_EN=0;
    - sample `oData<=LCD_DATA_IN`;
    - increment the poll counter;
    - go to HOLD.
  - HOLD: count HOLD_CYC cycles, then decide the next state:
    - If poll mode is active (latched iPoll=1 and latched iRS=0), oData[7]=1, and the poll counter < POLL_MAX: go to SETUP. oBusOwn, LCD_RW and LCD_RS stay unchanged.
    - If poll mode is active, oData[7]=1, and the poll counter = POLL_MAX: set oTimeout=1, then finish as below.
    - Otherwise (or after setting oTimeout): oDone=1, oBusOwn=0, LCD_RW=0, go to DONE.
- iPoll with latched iRS=1 is ignored; the transaction is a single read.
- iAbort, highest priority after reset, in any state:
  - next edge: LCD_EN=0, LCD_RW=0, oBusOwn=0, oDone=0, FSM to IDLE;
  - oData keeps its last value.
  - A start edge in the same cycle as iAbort is dropped.
- Counters are sized `$clog2(max+1)` bits. The cycle counter is shared across SETUP/EN_HI/HOLD and resets to 0 on every state change. The poll counter is 12 bits and never wraps.
- LCD_RS keeps the latched value after DONE until the next start.

## Timing
- Let t0 be the clock edge at which the start is accepted.
  - At t0: oBusOwn=1, LCD_RW=1, oDone=0.
  - LCD_EN rises at t0+SETUP_CYC.
  - LCD_EN falls at t0+SETUP_CYC+CLK_Divide; oData updates on that same edge.
  - End of a read at t0+SETUP_CYC+CLK_Divide+HOLD_CYC (20 cycles with defaults). At that edge the block either returns to SETUP (poll retry) or sets oDone=1 and oBusOwn=0.
- Each additional poll read adds SETUP_CYC+CLK_Divide+HOLD_CYC cycles.
- LCD_RW and LCD_RS never change while LCD_EN=1. LCD_EN is never high while oBusOwn=0.
- oDone is a level signal and stays high until the next accepted start or iAbort.

## Test plan
- Single data read: iRS=1, iPoll=0, LCD_DATA_IN=8'hA5, then an iStart 0→1.
  - LCD_EN is high for exactly 16 cycles starting at t0+2.
  - oData=8'hA5 from t0+18.
  - oDone=1 and oBusOwn=0 at t0+20.
  - LCD_RW=1 only between t0 and t0+20.
- Busy-flag poll: iRS=0, iPoll=1; LCD_DATA_IN=8'h80 for the first 3 reads, then 8'h12.
  - Exactly 4 EN pulses.
  - oData=8'h12, oDone=1 at t0+80, oTimeout=0.
- Poll timeout: POLL_MAX=3, LCD_DATA_IN fixed at 8'hFF.
  - 3 EN pulses.
  - oTimeout=1, oDone=1 at t0+60, oData=8'hFF.
- Start while busy: a second iStart edge at t0+5.
  - Ignored: exactly one EN pulse and a single oDone rise at t0+20.
  - A new edge after DONE starts a fresh read and clears oDone at its t0.
- iAbort at t0+10, while LCD_EN is high.
  - Next edge: LCD_EN=0, LCD_RW=0, oBusOwn=0, oDone=0.
  - oData is unchanged from its previous value.
- Async reset: drop iRST_N at t0+8.
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - After release, an iStart edge performs a normal 20-cycle read.
